// File: rtl/sys_array_tiler.sv
// sys_array_tiler: streams the M/K/N tile schedule of C = A*B for a bounded
// systolic array, one tile per valid/ready handshake.
module sys_array_tiler #(
  parameter int DIM_W  = 10,
  parameter int TILE_M = 10,
  parameter int TILE_K = 30,
  parameter int TILE_N = 10,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             order,
  input  logic [DIM_W-1:0] dim_m,
  input  logic [DIM_W-1:0] dim_k,
  input  logic [DIM_W-1:0] dim_n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [DIM_W-1:0] m0,
  output logic [DIM_W-1:0] m1,
  output logic [DIM_W-1:0] k0,
  output logic [DIM_W-1:0] k1,
  output logic [DIM_W-1:0] n0,
  output logic [DIM_W-1:0] n1,
  output logic             acc_first,
  output logic             acc_last,
  output logic [CNT_W-1:0] tile_idx,
  output logic             tile_last
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_EMIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam logic [DIM_W:0] L_M = (DIM_W+1)'(TILE_M);
  localparam logic [DIM_W:0] L_K = (DIM_W+1)'(TILE_K);
  localparam logic [DIM_W:0] L_N = (DIM_W+1)'(TILE_N);

  // range end = min(x0+tile, dim)-1, summed one bit wider so it cannot wrap
  function automatic logic [DIM_W-1:0] f_end(input logic [DIM_W-1:0] x0,
                                             input logic [DIM_W-1:0] dim,
                                             input logic [DIM_W:0]   tile);
    logic [DIM_W:0] s;
    s = {1'b0, x0} + tile;
    return (s < {1'b0, dim}) ? s[DIM_W-1:0] - 1'b1 : dim - 1'b1;
  endfunction

  logic [2:0]       r_state;
  logic [DIM_W-1:0] r_dm, r_dk, r_dn;
  logic             r_order;
  logic             w_load, w_hs, w_zero, w_mw, w_kw, w_nw;
  logic [DIM_W-1:0] w_nm, w_nk, w_nn, w_nm1, w_nk1, w_nn1;

  assign busy       = (r_state == S_CHECK) || (r_state == S_EMIT);
  assign done       = (r_state == S_DONE) || (r_state == S_ERR);
  assign tile_valid = (r_state == S_EMIT);
  assign w_hs       = tile_valid && tile_ready;
  assign w_zero     = (r_dm == '0) || (r_dk == '0) || (r_dn == '0);
  assign w_load     = (r_state == S_CHECK) && !w_zero;
  assign w_mw       = (m1 == r_dm - 1'b1);
  assign w_kw       = (k1 == r_dk - 1'b1);
  assign w_nw       = (n1 == r_dn - 1'b1);

  // order 0: k fastest, then n, then m; order 1: n fastest, then m, then k
  always_comb begin
    w_nk  = w_load ? '0 :
            (!r_order || (w_nw && w_mw)) ? (w_kw ? '0 : k1 + 1'b1) : k0;
    w_nn  = w_load ? '0 :
            (r_order || w_kw) ? (w_nw ? '0 : n1 + 1'b1) : n0;
    w_nm  = w_load ? '0 :
            (r_order ? w_nw : (w_kw && w_nw)) ? (w_mw ? '0 : m1 + 1'b1) : m0;
    w_nm1 = f_end(w_nm, r_dm, L_M);
    w_nk1 = f_end(w_nk, r_dk, L_K);
    w_nn1 = f_end(w_nn, r_dn, L_N);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_dm      <= '0;
      r_dk      <= '0;
      r_dn      <= '0;
      r_order   <= 1'b0;
      err       <= 1'b0;
      m0        <= '0;
      m1        <= '0;
      k0        <= '0;
      k1        <= '0;
      n0        <= '0;
      n1        <= '0;
      acc_first <= 1'b0;
      acc_last  <= 1'b0;
      tile_last <= 1'b0;
      tile_idx  <= '0;
    end else begin
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: if (start) begin
            r_dm    <= dim_m;
            r_dk    <= dim_k;
            r_dn    <= dim_n;
            r_order <= order;
            err     <= 1'b0;
            r_state <= S_CHECK;
          end
          S_CHECK: begin
            err     <= w_zero;
            r_state <= w_zero ? S_ERR : S_EMIT;
          end
          S_EMIT: if (w_hs && tile_last) r_state <= S_DONE;
          default: r_state <= S_IDLE;
        endcase
      end
      if (!abort && (w_load || (w_hs && !tile_last))) begin
        m0        <= w_nm;
        m1        <= w_nm1;
        k0        <= w_nk;
        k1        <= w_nk1;
        n0        <= w_nn;
        n1        <= w_nn1;
        acc_first <= (w_nk == '0);
        acc_last  <= (w_nk1 == r_dk - 1'b1);
        tile_last <= (w_nm1 == r_dm - 1'b1) && (w_nk1 == r_dk - 1'b1) &&
                     (w_nn1 == r_dn - 1'b1);
        tile_idx  <= w_load ? '0 : tile_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sys_array_tiler.sv
// tb_sys_array_tiler: directed checks of the tile schedule, backpressure,
// error, abort and mid-schedule reset behaviour.
module tb_sys_array_tiler;
  logic       clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic       order = 1'b0, tile_ready = 1'b0;
  logic [9:0] dim_m = '0, dim_k = '0, dim_n = '0;
  logic       busy, done, err, tile_valid, acc_first, acc_last, tile_last;
  logic [9:0] m0, m1, k0, k1, n0, n1;
  logic [15:0] tile_idx;
  int checks = 0, failures = 0;

  sys_array_tiler dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .order(order),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .busy(busy), .done(done),
    .err(err), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .m0(m0), .m1(m1), .k0(k0), .k1(k1), .n0(n0), .n1(n1),
    .acc_first(acc_first), .acc_last(acc_last), .tile_idx(tile_idx),
    .tile_last(tile_last)
  );

  always #5 clk = ~clk;

  logic [79:0] obs;
  assign obs = {tile_valid, m0, m1, k0, k1, n0, n1, acc_first, acc_last, tile_last, tile_idx};

  // expected tile t for M=25, K=64, N=10 with 10x30x10 tiles
  function automatic logic [79:0] exp_tile(input logic ord, input int t);
    int mi, ki;
    logic [9:0] a0, a1, b0, b1;
    mi = ord ? t % 3 : t / 3;
    ki = ord ? t / 3 : t % 3;
    a0 = 10'(mi * 10);
    a1 = (mi == 2) ? 10'd24 : 10'(mi * 10 + 9);
    b0 = 10'(ki * 30);
    b1 = (ki == 2) ? 10'd63 : 10'(ki * 30 + 29);
    return {1'b1, a0, a1, b0, b1, 10'd0, 10'd9, ki == 0, ki == 2, t == 8, 16'(t)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_sched(input logic ord, input logic [9:0] m, k, n);
    dim_m = m; dim_k = k; dim_n = n; order = ord; start = 1'b1;
    tick;
    start = 1'b0; dim_m = 10'd7; dim_k = 10'd7; dim_n = 10'd7; order = ~ord;
  endtask

  task automatic test_reset;
    checks++;
    if ({busy, done, err, tile_valid, m1, k1, n1, tile_idx, tile_last} !== '0) begin
      failures++;
      $display("FAIL reset got busy=%b done=%b err=%b valid=%b m1=%0d idx=%0d",
               busy, done, err, tile_valid, m1, tile_idx);
    end
  endtask

  task automatic test_single;
    tile_ready = 1'b1;
    start_sched(1'b0, 10'd1, 10'd1, 10'd1);
    checks++;
    if (busy !== 1'b1 || tile_valid !== 1'b0) begin
      failures++; $display("FAIL single_check busy=%b valid=%b exp 1/0", busy, tile_valid);
    end
    tick;
    checks++;
    if (obs !== {1'b1, 60'd0, 3'b111, 16'd0}) begin
      failures++; $display("FAIL single_tile got=%h exp=%h", obs, {1'b1, 60'd0, 3'b111, 16'd0});
    end
    tick;
    checks++;
    if (done !== 1'b1 || tile_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL single_done done=%b valid=%b busy=%b exp 1/0/0", done, tile_valid, busy);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL single_done_pulse done=%b exp 0", done);
    end
  endtask

  task automatic run_sched(input logic ord, input int stall);
    tile_ready = 1'b1;
    start_sched(ord, 10'd25, 10'd64, 10'd10);
    tick;
    for (int t = 0; t < 9; t++) begin
      checks++;
      if (obs !== exp_tile(ord, t)) begin
        failures++; $display("FAIL tile ord=%0d t=%0d got=%h exp=%h", ord, t, obs, exp_tile(ord, t));
      end
      if (t == stall) begin
        tile_ready = 1'b0;
        repeat (5) begin
          tick;
          checks++;
          if (obs !== exp_tile(ord, t)) begin
            failures++; $display("FAIL stall t=%0d got=%h exp=%h", t, obs, exp_tile(ord, t));
          end
        end
        tile_ready = 1'b1;
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || tile_valid !== 1'b0) begin
      failures++; $display("FAIL sched_done ord=%0d done=%b valid=%b exp 1/0", ord, done, tile_valid);
    end
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL sched_idle done=%b busy=%b exp 0/0", done, busy);
    end
  endtask

  task automatic test_order0;       run_sched(1'b0, -1); endtask
  task automatic test_order1;       run_sched(1'b1, -1); endtask
  task automatic test_backpressure; run_sched(1'b0, 3);  endtask

  task automatic test_err;
    tile_ready = 1'b1;
    start_sched(1'b0, 10'd5, 10'd0, 10'd5);
    checks++;
    if (tile_valid !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL err_check valid=%b busy=%b exp 0/1", tile_valid, busy);
    end
    tick;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || tile_valid !== 1'b0) begin
      failures++; $display("FAIL err_state done=%b err=%b valid=%b exp 1/1/0", done, err, tile_valid);
    end
    tick;
    checks++;
    if (done !== 1'b0 || err !== 1'b1 || tile_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL err_sticky done=%b err=%b valid=%b busy=%b exp 0/1/0/0", done, err, tile_valid, busy);
    end
    start_sched(1'b0, 10'd1, 10'd1, 10'd1);
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_clear err=%b exp 0", err);
    end
    repeat (3) tick;
  endtask

  task automatic goto_idx4;
    tile_ready = 1'b1;
    start_sched(1'b0, 10'd25, 10'd64, 10'd10);
    tick;
    repeat (4) tick;
    checks++;
    if (obs !== exp_tile(1'b0, 4)) begin
      failures++; $display("FAIL reach_idx4 got=%h exp=%h", obs, exp_tile(1'b0, 4));
    end
  endtask

  task automatic check_restart(input string tag);
    tick;
    checks++;
    if (done !== 1'b0 || tile_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_quiet done=%b valid=%b busy=%b exp 0/0/0", tag, done, tile_valid, busy);
    end
    start_sched(1'b0, 10'd25, 10'd64, 10'd10);
    tick;
    checks++;
    if (obs !== exp_tile(1'b0, 0)) begin
      failures++; $display("FAIL %s_restart got=%h exp=%h", tag, obs, exp_tile(1'b0, 0));
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
  endtask

  task automatic test_abort;
    goto_idx4;
    abort = 1'b1;
    start = 1'b1;
    tick;
    abort = 1'b0;
    start = 1'b0;
    checks++;
    if (tile_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort valid=%b busy=%b done=%b exp 0/0/0", tile_valid, busy, done);
    end
    check_restart("abort");
  endtask

  task automatic test_reset_mid;
    goto_idx4;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tile_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || tile_idx !== 16'd0 || m1 !== 10'd0) begin
      failures++; $display("FAIL reset_mid valid=%b busy=%b done=%b idx=%0d m1=%0d exp all 0",
                           tile_valid, busy, done, tile_idx, m1);
    end
    tick;
    reset_n = 1'b1;
    check_restart("rstmid");
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick;
    tick;
    test_reset;
    reset_n = 1'b1;
    tick;
    test_single;
    test_order0;
    test_order1;
    test_backpressure;
    test_err;
    test_abort;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
